// File: rtl/hex_display_scheduler_if.sv
// Load/status bus between game logic and the six-digit seven-segment scheduler.
interface hex_display_scheduler_if #(parameter int VALUE_W = 20);
  logic               load_i;
  logic [VALUE_W-1:0] value_i;
  logic               hex_mode_i;
  logic               blank_lz_i;
  logic               busy_o;
  logic               done_o;
  logic               overflow_o;
  logic [6:0]         HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (output load_i, value_i, hex_mode_i, blank_lz_i,
                  input  busy_o, done_o, overflow_o, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
  modport slave  (input  load_i, value_i, hex_mode_i, blank_lz_i,
                  output busy_o, done_o, overflow_o, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5);
endinterface

// File: rtl/hex_display_scheduler.sv
// Binary -> six seven-segment digits: serial double dabble, one shared decoder,
// staged digits committed together so the display never tears.
module hexDecoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h18;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  end
endmodule

module hex_display_scheduler #(parameter int VALUE_W = 20) (
  input logic clock,
  input logic reset,
  hex_display_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONVERT, DECODE, COMMIT} state_t;
  state_t state, nextState;

  logic [VALUE_W-1:0] shiftReg, pendValue, startValue;
  logic [23:0]        digits, adj, effDigits;
  logic [4:0]         cnt;
  logic [2:0]         digIdx;
  logic               capOvf, capBlank, startHex, startBlank, start;
  logic               pendValid, pendHex, pendBlank;
  logic               busy, done, ovf;
  logic [6:0]         stage [6];
  logic [6:0]         hexReg [6];
  logic [3:0]         decDigit;
  logic [6:0]         decSeg;
  logic               blankThis;

  // A fresh load always beats a queued request.
  assign startValue = bus.load_i ? bus.value_i    : pendValue;
  assign startHex   = bus.load_i ? bus.hex_mode_i : pendHex;
  assign startBlank = bus.load_i ? bus.blank_lz_i : pendBlank;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    start     = 1'b0;
    case (state)
      IDLE: if (bus.load_i || pendValid) begin
        start     = 1'b1;
        nextState = startHex ? DECODE : CONVERT;
      end
      CONVERT: if (cnt == 5'(VALUE_W-1)) nextState = DECODE;
      DECODE:  if (digIdx == 3'd5)       nextState = COMMIT;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < 6; i++)
      adj[4*i +: 4] = (digits[4*i +: 4] >= 4'd5) ? digits[4*i +: 4] + 4'd3 : digits[4*i +: 4];
  end

  // Overflowed decimal values display as all nines, which also defeats blanking.
  assign effDigits = capOvf ? 24'h999999 : digits;
  assign decDigit  = effDigits[{digIdx, 2'b00} +: 4];
  assign blankThis = capBlank && (digIdx != 3'd0) && ((effDigits >> {digIdx, 2'b00}) == 24'd0);

  hexDecoder uDec (.digit(decDigit), .seg(decSeg));

  always_ff @(posedge clock) begin
    if (reset) begin
      shiftReg  <= '0;  digits    <= '0;  cnt     <= '0;  digIdx <= '0;
      capOvf    <= 1'b0; capBlank <= 1'b0;
      pendValid <= 1'b0; pendValue <= '0; pendHex <= 1'b0; pendBlank <= 1'b0;
      busy      <= 1'b0; done     <= 1'b0; ovf    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        stage[i]  <= 7'h7F;
        hexReg[i] <= 7'h7F;
      end
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          pendValid <= 1'b0;
          shiftReg  <= startValue;
          digits    <= startHex ? 24'(startValue) : 24'd0;
          capOvf    <= !startHex && (25'(startValue) > 25'd999999);
          capBlank  <= startBlank;
          cnt       <= '0;
          digIdx    <= '0;
          busy      <= 1'b1;
        end
      end else if (bus.load_i) begin
        pendValid <= 1'b1;
        pendValue <= bus.value_i;
        pendHex   <= bus.hex_mode_i;
        pendBlank <= bus.blank_lz_i;
      end
      case (state)
        CONVERT: begin
          digits   <= {adj[22:0], shiftReg[VALUE_W-1]};
          shiftReg <= {shiftReg[VALUE_W-2:0], 1'b0};
          cnt      <= cnt + 5'd1;
        end
        DECODE: begin
          stage[digIdx] <= blankThis ? 7'h7F : decSeg;
          digIdx        <= digIdx + 3'd1;
        end
        COMMIT: begin
          hexReg <= stage;
          ovf    <= capOvf;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.overflow_o = ovf;
  assign bus.HEX0 = hexReg[0];
  assign bus.HEX1 = hexReg[1];
  assign bus.HEX2 = hexReg[2];
  assign bus.HEX3 = hexReg[3];
  assign bus.HEX4 = hexReg[4];
  assign bus.HEX5 = hexReg[5];
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with hand-computed segment patterns.
module tb_hex_display_scheduler;
  localparam int W = 20;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  hex_display_scheduler_if #(.VALUE_W(W)) bus ();
  hex_display_scheduler #(.VALUE_W(W)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkHex(input string tag, input logic [6:0] e5, e4, e3, e2, e1, e0);
    chk({tag, ".HEX5"}, 32'(bus.HEX5), 32'(e5));
    chk({tag, ".HEX4"}, 32'(bus.HEX4), 32'(e4));
    chk({tag, ".HEX3"}, 32'(bus.HEX3), 32'(e3));
    chk({tag, ".HEX2"}, 32'(bus.HEX2), 32'(e2));
    chk({tag, ".HEX1"}, 32'(bus.HEX1), 32'(e1));
    chk({tag, ".HEX0"}, 32'(bus.HEX0), 32'(e0));
  endtask

  task automatic doLoad(input logic [W-1:0] v, input logic hexMode, input logic blank);
    bus.load_i     = 1'b1;
    bus.value_i    = v;
    bus.hex_mode_i = hexMode;
    bus.blank_lz_i = blank;
    step();
    bus.load_i     = 1'b0;
  endtask

  // Returns edges from the current sample to the first done_o sample, and busy samples seen.
  task automatic waitDone(output int n, output int busyCyc);
    n = 0;
    busyCyc = bus.busy_o ? 1 : 0;
    while (!bus.done_o && n < 100) begin
      step();
      n++;
      if (bus.busy_o) busyCyc++;
    end
    if (n >= 100) chk("doneTimeout", 32'(n), 32'd0);
  endtask

  task automatic runJob(input string tag, input logic [W-1:0] v, input logic hexMode,
                        input logic blank, input int expLat);
    int n, b;
    doLoad(v, hexMode, blank);
    waitDone(n, b);
    chk({tag, ".latency"}, 32'(n), 32'(expLat));
    chk({tag, ".busyCycles"}, 32'(b), 32'(expLat));
  endtask

  initial begin
    int n, b, doneCnt;
    bus.load_i = 1'b0; bus.value_i = '0; bus.hex_mode_i = 1'b0; bus.blank_lz_i = 1'b0;

    step(); step();
    reset = 1'b0;
    chkHex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("reset.busy", 32'(bus.busy_o), 0);
    chk("reset.done", 32'(bus.done_o), 0);
    chk("reset.ovf",  32'(bus.overflow_o), 0);

    // abort mid-CONVERT: nothing may commit afterwards
    doLoad(W'(123456), 1'b0, 1'b0);
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done_o) doneCnt++;
    end
    chk("abort.doneCount", 32'(doneCnt), 0);
    chk("abort.busy", 32'(bus.busy_o), 0);
    chkHex("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    runJob("dec123456", W'(123456), 1'b0, 1'b0, 27);
    chkHex("dec123456", 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
    chk("dec123456.ovf", 32'(bus.overflow_o), 0);
    step();
    chk("dec123456.donePulse", 32'(bus.done_o), 0);

    runJob("blank7", W'(7), 1'b0, 1'b1, 27);
    chkHex("blank7", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    step();
    runJob("blank0", W'(0), 1'b0, 1'b1, 27);
    chkHex("blank0", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    step();
    runJob("zeroNoBlank", W'(0), 1'b0, 1'b0, 27);
    chkHex("zeroNoBlank", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    step();

    runJob("hexAF09", W'(20'hAF09), 1'b1, 1'b0, 7);
    chkHex("hexAF09", 7'h40, 7'h40, 7'h08, 7'h0E, 7'h40, 7'h18);
    chk("hexAF09.ovf", 32'(bus.overflow_o), 0);
    step();

    runJob("ovf", W'(1000000), 1'b0, 1'b1, 27);
    chkHex("ovf", 7'h18, 7'h18, 7'h18, 7'h18, 7'h18, 7'h18);
    chk("ovf.flag", 32'(bus.overflow_o), 1);
    step();
    chk("ovf.flagHolds", 32'(bus.overflow_o), 1);
    runJob("after5", W'(5), 1'b0, 1'b1, 27);
    chkHex("after5", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12);
    chk("after5.ovf", 32'(bus.overflow_o), 0);
    step();

    // pending slot: 2 is overwritten by 3 before the first job finishes
    doLoad(W'(1), 1'b0, 1'b1);
    repeat (3) step();
    doLoad(W'(2), 1'b0, 1'b1);
    repeat (2) step();
    doLoad(W'(3), 1'b0, 1'b1);
    waitDone(n, b);
    chk("pend1.finished", 32'(n < 100), 1);
    chkHex("pend1", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79);
    chk("pend1.idleGap", 32'(bus.busy_o), 0);
    step();
    chk("pend2.start.busy", 32'(bus.busy_o), 1);
    chk("pend2.start.done", 32'(bus.done_o), 0);
    waitDone(n, b);
    chk("pend2.latency", 32'(n), 27);
    chkHex("pend2", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done_o) doneCnt++;
    end
    chk("pend.noThirdJob", 32'(doneCnt), 0);
    chk("pend.finalBusy", 32'(bus.busy_o), 0);
    chk("pend.finalHEX0", 32'(bus.HEX0), 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
